// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath width and the memory
// port arbiter state encoding.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage : rv32_pkg

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified instruction/data memory.
// The IF stage (fetch) and the MEM stage (load/store) each raise a level
// request and hold it until a one-cycle ack. Data wins simultaneous
// requests. The requester being acked this cycle is masked from arbitration,
// so two continuously pending requesters alternate. A watchdog aborts any
// access whose memory never signals ready, and acks it with bus_err.
module mem_port_arbiter #(
  parameter int XLEN    = rv32_pkg::XLEN,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_ack,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [XLEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN/8-1:0] dm_wstrb,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_ack,
  // memory command, registered
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  // pipeline hazard interface
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  // A TIMEOUT of 0 still needs a one-bit counter so the declarations stay
  // legal; the enable flag keeps it from ever aborting.
  localparam bit              WDOG_EN = (TIMEOUT > 0);
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  rv32_pkg::arb_state_t state, state_next;
  logic [CNT_W-1:0]     wd_cnt;

  logic grant_dm;
  logic grant_if;
  logic done;
  logic abort;

  // Stalls follow the requester until its ack shows up, then drop in that
  // same cycle so the pipeline register captures the returned data.
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= rv32_pkg::IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample the values
      // from before the edge; a blocking = here would let later statements
      // see the new value and build an unintended combinational chain.
      state <= state_next;
    end
  end

  // Arbitration, completion/abort detection and next-state selection.
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;

    case (state)
      rv32_pkg::IDLE: begin
        // The requester acked this cycle is still holding its request, so it
        // is masked out; that mask is what produces alternation.
        grant_dm = dm_req & ~dm_ack;
        grant_if = if_req & ~if_ack & ~grant_dm;
        if (grant_dm) begin
          state_next = rv32_pkg::DATA;
        end else if (grant_if) begin
          state_next = rv32_pkg::FETCH;
        end
      end
      rv32_pkg::FETCH, rv32_pkg::DATA: begin
        // Ready in the same cycle the watchdog expires is a normal completion.
        done  = mem_ready;
        abort = ~mem_ready & WDOG_EN & (wd_cnt == CNT_MAX);
        if (done || abort) begin
          state_next = rv32_pkg::IDLE;
        end
      end
      default: begin
        state_next = rv32_pkg::IDLE;
      end
    endcase
  end

  // Memory command, returned data, acks and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the rdata holding registers are reset along with the control
      // flops; they are only two words, and a defined value after reset keeps
      // downstream logic from ever sampling X.
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      bus_err   <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;

      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_wstrb <= dm_wstrb;
        wd_cnt    <= '0;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        wd_cnt    <= '0;
      end else if (done) begin
        // Stores also refresh dm_rdata; its content is meaningless then.
        mem_req <= 1'b0;
        if (state == rv32_pkg::FETCH) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          dm_rdata <= mem_rdata;
          dm_ack   <= 1'b1;
        end
      end else if (abort) begin
        mem_req <= 1'b0;
        bus_err <= 1'b1;
        if (state == rv32_pkg::FETCH) begin
          if_rdata <= '0;
          if_ack   <= 1'b1;
        end else begin
          dm_rdata <= '0;
          dm_ack   <= 1'b1;
        end
      end else if (state != rv32_pkg::IDLE) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling edge; "cycle N" of a
// scenario is the N-th falling edge after the request is first driven.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_ack;
  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [3:0]      dm_wstrb;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_ack;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            stall_if;
  logic            stall_mem;
  logic            bus_err;

  int n_checks = 0;
  int n_err    = 0;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wstrb  (dm_wstrb),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_wstrb  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_if_ack",    if_ack,    0);
    check("rst_dm_ack",    dm_ack,    0);
    check("rst_bus_err",   bus_err,   0);
    check("rst_if_rdata",  if_rdata,  0);
    check("rst_dm_rdata",  dm_rdata,  0);
    rst = 1'b0;

    // ---------------- fetch only, zero wait ----------------
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0050_0093;
    #1;
    check("f_stall_c0",  stall_if, 1);
    check("f_memreq_c0", mem_req,  0);
    @(negedge clk);
    check("f_memreq_c1", mem_req,   1);
    check("f_addr_c1",   mem_addr,  32'h100);
    check("f_we_c1",     mem_we,    0);
    check("f_wstrb_c1",  mem_wstrb, 0);
    check("f_stall_c1",  stall_if,  1);
    check("f_ack_c1",    if_ack,    0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("f_ack_c2",    if_ack,    1);
    check("f_rdata_c2",  if_rdata,  32'h0050_0093);
    check("f_stall_c2",  stall_if,  0);
    check("f_memreq_c2", mem_req,   0);
    check("f_buserr_c2", bus_err,   0);
    mem_ready = 1'b0;   // if_req still high in the ack cycle: must be masked
    @(negedge clk);
    check("f_mask_c3",   mem_req,   0);
    check("f_ack_c3",    if_ack,    0);
    if_req = 1'b0; mem_ready = 1'b1;   // ready while idle is ignored
    @(negedge clk);
    check("idle_rdy_ifack", if_ack,  0);
    check("idle_rdy_dmack", dm_ack,  0);
    check("idle_rdy_req",   mem_req, 0);
    mem_ready = 1'b0;

    // ---------------- simultaneous requests: data first ----------------
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    mem_rdata = 32'h1111_2222; mem_ready = 1'b1;
    @(negedge clk);
    check("p_memreq_c1", mem_req,  1);
    check("p_addr_c1",   mem_addr, 32'h2000);
    check("p_we_c1",     mem_we,   0);
    check("p_stallif_c1", stall_if, 1);
    @(negedge clk);
    check("p_dmack_c2",  dm_ack,   1);
    check("p_dmrd_c2",   dm_rdata, 32'h1111_2222);
    check("p_ifack_c2",  if_ack,   0);
    check("p_stallm_c2", stall_mem, 0);
    check("p_stallif_c2", stall_if, 1);
    dm_req = 1'b0; mem_rdata = 32'h3333_4444;
    @(negedge clk);
    check("p_memreq_c3", mem_req,  1);
    check("p_addr_c3",   mem_addr, 32'h104);
    check("p_dmack_c3",  dm_ack,   0);
    @(negedge clk);
    check("p_ifack_c4",  if_ack,   1);
    check("p_ifrd_c4",   if_rdata, 32'h3333_4444);
    check("p_dmhold_c4", dm_rdata, 32'h1111_2222);
    if_req = 1'b0; mem_ready = 1'b0;

    // ---------------- store with 3 wait states ----------------
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011; mem_rdata = 32'h55AA_55AA;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("s_memreq", mem_req,   1);
      check("s_we",     mem_we,    1);
      check("s_addr",   mem_addr,  32'h3000);
      check("s_wdata",  mem_wdata, 32'hDEAD_BEEF);
      check("s_wstrb",  mem_wstrb, 4'b0011);
      check("s_noack",  dm_ack,    0);
      if (k == 1) begin
        // command must stay latched even if the requester inputs move
        dm_addr = 32'hFFFF_FFFC; dm_wdata = 32'h0; dm_wstrb = 4'hF; dm_we = 1'b0;
      end
      if (k == 4) mem_ready = 1'b1;
    end
    @(negedge clk);
    check("s_ack_c5",    dm_ack,  1);
    check("s_buserr_c5", bus_err, 0);
    check("s_memreq_c5", mem_req, 0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;

    // ---------------- both held: alternation ----------------
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
    mem_rdata = 32'h0BAD_F00D; mem_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("a_dmack",  dm_ack,  (k % 4) == 2);
      check("a_ifack",  if_ack,  (k % 4) == 0);
      check("a_memreq", mem_req, (k % 2) == 1);
      if ((k % 2) == 1)
        check("a_addr", mem_addr, ((k % 4) == 1) ? 32'h4000 : 32'h200);
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("a_idle_req", mem_req, 0);

    // ---------------- watchdog abort (TIMEOUT = 4) ----------------
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h5000; mem_rdata = 32'h7777_7777;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("w_memreq", mem_req, 1);
      check("w_noack",  dm_ack,  0);
      check("w_noerr",  bus_err, 0);
    end
    @(negedge clk);
    check("w_ack_c6",    dm_ack,   1);
    check("w_err_c6",    bus_err,  1);
    check("w_rdata_c6",  dm_rdata, 0);
    check("w_memreq_c6", mem_req,  0);
    dm_req = 1'b0;
    @(negedge clk);
    check("w_memreq_c7", mem_req, 0);
    check("w_err_c7",    bus_err, 0);
    check("w_ack_c7",    dm_ack,  0);

    // ---------------- ready exactly at timeout: normal completion ----------------
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h5004; mem_rdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("wr_memreq", mem_req, 1);
      check("wr_noack",  dm_ack,  0);
      if (k == 5) mem_ready = 1'b1;
    end
    @(negedge clk);
    check("wr_ack_c6",   dm_ack,   1);
    check("wr_noerr_c6", bus_err,  0);
    check("wr_rdata_c6", dm_rdata, 32'hCAFE_F00D);
    dm_req = 1'b0; mem_ready = 1'b0;

    // ---------------- reset during a waiting fetch ----------------
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    check("r_memreq_c1", mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_memreq_rst", mem_req,  0);
    check("r_addr_rst",   mem_addr, 0);
    check("r_ifack_rst",  if_ack,   0);
    check("r_ifrd_rst",   if_rdata, 0);
    check("r_dmrd_rst",   dm_rdata, 0);
    @(negedge clk);
    check("r_ifack_hold", if_ack,  0);
    check("r_memreq_hold", mem_req, 0);
    rst = 1'b0; mem_rdata = 32'h00A0_0113; mem_ready = 1'b1;
    @(negedge clk);
    check("r_memreq_new", mem_req,  1);
    check("r_addr_new",   mem_addr, 32'h600);
    @(negedge clk);
    check("r_ifack_new",  if_ack,   1);
    check("r_ifrd_new",   if_rdata, 32'h00A0_0113);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("r_ifack_done", if_ack, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the RV32I pipeline. Requesters use a level request with a one-cycle acknowledge; the arbiter emits the stall signals consumed by the hazard/pipeline-register logic. A watchdog aborts memory accesses that never complete. It sits between the pipeline front/back ends and the memory.

## Interface
- `XLEN`, 32: address/data width.
- `TIMEOUT`, 16: max cycles `mem_ready` may stay low with `mem_req` high before abort. 0 disables the watchdog.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  XLEN  fetch address.
- `if_rdata`  out  XLEN  fetched word, valid with `if_ack`.
- `if_ack`  out  1  one-cycle completion pulse.
- `dm_req`  in  1  data request, held until `dm_ack`.
- `dm_we`  in  1  1 = store.
- `dm_addr`  in  XLEN  data address.
- `dm_wdata`  in  XLEN  store data.
- `dm_wstrb`  in  XLEN/8  byte enables.
- `dm_rdata`  out  XLEN  load data, valid with `dm_ack`.
- `dm_ack`  out  1  one-cycle completion pulse.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/1/XLEN/XLEN/XLEN/8  memory command, registered.
- `mem_rdata`  in  XLEN  memory read data, sampled with `mem_ready`.
- `mem_ready`  in  1  memory completes the current command this cycle.
- `stall_if`  out  1  `if_req & ~if_ack`.
- `stall_mem`  out  1  `dm_req & ~dm_ack`.
- `bus_err`  out  1  one-cycle pulse, coincident with the ack of an aborted access.

## Operation
- States: IDLE, FETCH, DATA.
- IDLE: arbitrate over requests not masked. Mask = the requester whose ack is asserted this cycle. Data has priority over fetch. On grant, latch the command into the `mem_*` registers and go to FETCH/DATA. A fetch latches `mem_we=0` and `mem_wstrb=0`.
- FETCH/DATA: `mem_req=1` with the latched command held stable, regardless of requester inputs. On `mem_ready=1`:
  - register `mem_rdata` into `if_rdata` or `dm_rdata`;
  - pulse the matching ack next cycle;
  - drop `mem_req`;
  - return to IDLE.
- Store acks also update `dm_rdata`, with don't-care content.
- Watchdog: the counter clears on grant and increments each cycle in FETCH/DATA while `mem_ready=0`. When it reaches `TIMEOUT`, abort: ack the requester with `rdata=0` and `bus_err=1`, drop `mem_req`, go to IDLE.
- Masking plus priority gives alternation when both requesters are continuously pending. Neither requester can starve.
- `rdata` outputs hold their last value between acks.

## Timing
- Reset (async assert, sync deassert by system): state IDLE; `mem_req`/`mem_we`=0; `mem_addr`/`mem_wdata`/`mem_wstrb`=0; acks 0; `bus_err` 0; `rdata` outputs 0; watchdog 0.
- Reset mid-access abandons the transaction with no ack. The memory must tolerate `mem_req` falling without `mem_ready`.
- Latency with zero-wait memory:
  - request seen in cycle 0;
  - `mem_req` in cycle 1, `mem_ready` in cycle 1;
  - ack in cycle 2.
  - Each wait state adds one cycle.
- Throughput is one access per 2 cycles. A new grant can occur in the ack cycle for the other requester.
- `stall_if`/`stall_mem` are combinational from registered acks and inputs. They are low in the ack cycle.
- Simultaneous `if_req` and `dm_req` in IDLE with no mask: DATA wins.
- `mem_ready` in the same cycle the watchdog hits `TIMEOUT`: normal completion wins, no `bus_err`.
- `mem_ready` while IDLE is ignored.

## Structure
- The shared package `rv32_pkg` holds:
  - the `arb_state_t` enum (IDLE, FETCH, DATA);
  - the `XLEN` default;
  - `STRB_W = XLEN/8`.
- Single module with no sub-module. The watchdog is an inline `$clog2(TIMEOUT+1)`-bit counter.

## Test plan
- Fetch only, zero-wait memory, `if_addr=0x100`, `mem_rdata=0x00500093` -> `mem_req` cycle 1, `if_ack` cycle 2 with `if_rdata=0x00500093`; `stall_if` high cycles 0–1.
- `if_req` and `dm_req` (load 0x2000) both asserted in cycle 0 -> DATA first (`mem_addr=0x2000`), `dm_ack` cycle 2, fetch granted cycle 2, `if_ack` cycle 4.
- Store with 3 wait states, `dm_wstrb=4'b0011`, `dm_wdata=0xDEADBEEF` -> `mem_*` held constant through cycles 1–4, `dm_ack` cycle 5, `mem_we=1` throughout.
- Both requesters held high for 10 cycles -> grants alternate DATA/FETCH/DATA, with each ack spaced 2 cycles.
- `TIMEOUT=4`, `mem_ready` stuck low -> `dm_ack` and `bus_err` pulse together, `dm_rdata=0`, `mem_req` low afterwards.
- `rst` asserted in cycle 2 of a waiting fetch -> outputs return to reset values immediately with no ack. After release, a fresh fetch completes normally.
